// File: rtl/cancid_pkg.sv
// Shared definitions for the stream-context block: FSM encoding and
// default parameter values.
package cancid_pkg;

  localparam int DEF_NUM_STREAMS = 64;
  localparam int DEF_STATE_W     = 11;
  localparam int DEF_CNT_W       = 16;
  localparam int CHAR_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2
  } ctx_state_e;

endpackage

// File: rtl/cancid_ctx_ram.sv
// Per-stream context storage: saved engine state and match counter.
// One synchronous write port, two asynchronous read ports
// (A: context of the active stream, B: counter readout).
module cancid_ctx_ram #(
  parameter  int NUM_STREAMS = 64,
  parameter  int STATE_W     = 11,
  parameter  int CNT_W       = 16,
  localparam int SID_W       = $clog2(NUM_STREAMS)
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [SID_W-1:0]   i_waddr,
  input  logic [STATE_W-1:0] i_wstate,
  input  logic [CNT_W-1:0]   i_wcnt,
  input  logic [SID_W-1:0]   i_raddr_a,
  output logic [STATE_W-1:0] o_rstate_a,
  output logic [CNT_W-1:0]   o_rcnt_a,
  input  logic [SID_W-1:0]   i_raddr_b,
  output logic [CNT_W-1:0]   o_rcnt_b
);

  logic [STATE_W-1:0] r_state_mem [NUM_STREAMS];
  logic [CNT_W-1:0]   r_cnt_mem   [NUM_STREAMS];

  // Write port; contents are never reset, validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_state_mem[i_waddr] <= i_wstate;
      r_cnt_mem[i_waddr]   <= i_wcnt;
    end
  end

  assign o_rstate_a = r_state_mem[i_raddr_a];
  assign o_rcnt_a   = r_cnt_mem[i_raddr_a];
  assign o_rcnt_b   = r_cnt_mem[i_raddr_b];

endmodule

// File: rtl/cancid_stream_ctx.sv
// Stream context manager for a shared regex engine: restores per-stream
// engine state at packet start, saves it at end of packet, and keeps
// saturating per-stream and total match counters.
module cancid_stream_ctx
  import cancid_pkg::*;
#(
  parameter  int NUM_STREAMS = DEF_NUM_STREAMS,
  parameter  int STATE_W     = DEF_STATE_W,
  parameter  int CNT_W       = DEF_CNT_W,
  localparam int SID_W       = $clog2(NUM_STREAMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_state,
  input  logic               new_stream_id,
  input  logic [SID_W-1:0]   stream_id,
  input  logic               enable,
  input  logic               char_in_vld,
  input  logic [CHAR_W-1:0]  char_in,
  input  logic               eop,
  output logic               eng_char_vld,
  output logic [CHAR_W-1:0]  eng_char,
  output logic [STATE_W-1:0] eng_state_in,
  output logic               eng_state_in_vld,
  input  logic [STATE_W-1:0] eng_state_out,
  input  logic               eng_accept,
  output logic               fired,
  output logic [CNT_W-1:0]   total_count,
  input  logic [SID_W-1:0]   rd_sid,
  output logic [CNT_W-1:0]   rd_count,
  output logic               proto_err
);

  ctx_state_e         r_state;
  ctx_state_e         w_next;
  logic [SID_W-1:0]   r_sid;
  logic               r_new;
  logic               r_flag;
  logic [CNT_W-1:0]   r_total;
  logic [CNT_W-1:0]   r_rd_count;
  logic               r_proto;
  logic [NUM_STREAMS-1:0] r_valid;

  logic               w_active;
  logic               w_fired;
  logic               w_commit;
  logic               w_inc;
  logic               w_load_ok;
  logic               w_perr;
  logic [STATE_W-1:0] w_ram_state;
  logic [CNT_W-1:0]   w_ram_cnt_a;
  logic [CNT_W-1:0]   w_ram_cnt_b;
  logic [CNT_W-1:0]   w_cnt_cur;
  logic [CNT_W-1:0]   w_cnt_new;

  assign w_active  = (r_state == ST_ACTIVE);
  assign w_fired   = r_flag | (w_active & eng_accept);
  assign w_commit  = w_active & eop & enable;
  assign w_inc     = w_commit & w_fired;
  // load_state is honoured in IDLE and ACTIVE, never while already loading
  assign w_load_ok = load_state & (r_state != ST_LOAD);
  assign w_perr    = (eop & ~w_active) | (load_state & (r_state == ST_LOAD))
                   | (char_in_vld & ~w_active);

  // A counter slot not written since reset reads as zero
  assign w_cnt_cur = r_valid[r_sid] ? w_ram_cnt_a : '0;
  assign w_cnt_new = (w_inc && (w_cnt_cur != '1)) ? w_cnt_cur + 1'b1 : w_cnt_cur;

  cancid_ctx_ram #(
    .NUM_STREAMS (NUM_STREAMS),
    .STATE_W     (STATE_W),
    .CNT_W       (CNT_W)
  ) u_ram (
    .clk        (clk),
    .i_we       (w_commit),
    .i_waddr    (r_sid),
    .i_wstate   (eng_state_out),
    .i_wcnt     (w_cnt_new),
    .i_raddr_a  (r_sid),
    .o_rstate_a (w_ram_state),
    .o_rcnt_a   (w_ram_cnt_a),
    .i_raddr_b  (rd_sid),
    .o_rcnt_b   (w_ram_cnt_b)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a load during ACTIVE wins over eop (commit still happens)
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (load_state) w_next = ST_LOAD;
      ST_LOAD:   w_next = ST_ACTIVE;
      ST_ACTIVE: begin
        if (load_state)  w_next = ST_LOAD;
        else if (eop)    w_next = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // Latch stream id and new-stream qualifier at an accepted load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sid <= '0;
      r_new <= 1'b0;
    end else if (w_load_ok) begin
      r_sid <= stream_id;
      r_new <= new_stream_id;
    end
  end

  // Speculative match flag: cleared by load or disabled eop, set by accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_flag <= 1'b0;
    else if (w_load_ok)                      r_flag <= 1'b0;
    else if (w_active && eop && !enable)     r_flag <= 1'b0;
    else if (w_active && eng_accept)         r_flag <= 1'b1;
  end

  // Per-stream valid bits and saturating total counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_total <= '0;
    end else if (w_commit) begin
      r_valid[r_sid] <= 1'b1;
      if (w_inc && (r_total != '1)) r_total <= r_total + 1'b1;
    end
  end

  // Registered counter readout, write-first against a same-cycle commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_rd_count <= '0;
    else if (w_commit && rd_sid == r_sid) r_rd_count <= w_cnt_new;
    else if (r_valid[rd_sid])         r_rd_count <= w_ram_cnt_b;
    else                              r_rd_count <= '0;
  end

  // Sticky protocol-violation flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_proto <= 1'b0;
    else     r_proto <= r_proto | w_perr;
  end

  assign eng_state_in_vld = (r_state == ST_LOAD);
  assign eng_state_in     = (eng_state_in_vld && !r_new && r_valid[r_sid]) ? w_ram_state : '0;
  assign eng_char_vld     = char_in_vld;
  assign eng_char         = char_in;
  assign fired            = w_fired;
  assign total_count      = r_total;
  assign rd_count         = r_rd_count;
  assign proto_err        = r_proto;

endmodule

// File: tb/tb_cancid_stream_ctx.sv
// Self-checking bench for cancid_stream_ctx with a small reference model
// and a queue of expected values.
module tb_cancid_stream_ctx;

  localparam int NS   = 8;
  localparam int SW   = 11;
  localparam int CW   = 4;
  localparam int SIDW = 3;
  localparam int CMAX = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_state, new_stream_id, enable, char_in_vld, eop, eng_accept;
  logic [SIDW-1:0] stream_id, rd_sid;
  logic [7:0]      char_in, eng_char;
  logic            eng_char_vld, eng_state_in_vld, fired, proto_err;
  logic [SW-1:0]   eng_state_in, eng_state_out;
  logic [CW-1:0]   total_count, rd_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] sb_q[$];
  logic [31:0] exp_v;

  bit          m_valid [NS];
  int          m_state [NS];
  int          m_cnt   [NS];
  int          m_total;
  bit          m_flag;
  int          m_sid;

  cancid_stream_ctx #(
    .NUM_STREAMS (NS),
    .STATE_W     (SW),
    .CNT_W       (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .load_state       (load_state),
    .new_stream_id    (new_stream_id),
    .stream_id        (stream_id),
    .enable           (enable),
    .char_in_vld      (char_in_vld),
    .char_in          (char_in),
    .eop              (eop),
    .eng_char_vld     (eng_char_vld),
    .eng_char         (eng_char),
    .eng_state_in     (eng_state_in),
    .eng_state_in_vld (eng_state_in_vld),
    .eng_state_out    (eng_state_out),
    .eng_accept       (eng_accept),
    .fired            (fired),
    .total_count      (total_count),
    .rd_sid           (rd_sid),
    .rd_count         (rd_count),
    .proto_err        (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 0; m_cnt[i] = 0; m_state[i] = 0;
    end
    m_total = 0; m_flag = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    load_state = 0; new_stream_id = 0; stream_id = '0; enable = 0;
    char_in_vld = 0; char_in = '0; eop = 0; eng_accept = 0;
    eng_state_out = '0; rd_sid = '0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Start a packet, check the LOAD cycle, end in ACTIVE
  task automatic do_load(input int sid, input bit newf);
    load_state = 1; stream_id = SIDW'(sid); new_stream_id = newf;
    sb_q.push_back((newf || !m_valid[sid]) ? 32'd0 : 32'(m_state[sid]));
    m_flag = 0; m_sid = sid;
    tick();
    load_state = 0; new_stream_id = 0;
    exp_v = sb_q.pop_front();
    total++;
    if (eng_state_in_vld !== 1'b1 || 32'(eng_state_in) !== exp_v) begin
      bad++;
      $display("FAIL load sid=%0d: got vld=%b st=%h, want vld=1 st=%h", sid, eng_state_in_vld, eng_state_in, exp_v);
    end
    tick();
    total++;
    if (eng_state_in_vld !== 1'b0) begin
      bad++;
      $display("FAIL load_vld_pulse sid=%0d: got vld=%b, want 0", sid, eng_state_in_vld);
    end
  endtask

  task automatic do_accept();
    eng_accept = 1;
    tick();
    eng_accept = 0;
    m_flag = 1;
    total++;
    if (fired !== 1'b1) begin
      bad++;
      $display("FAIL accept_fired: got %b, want 1", fired);
    end
  endtask

  // End the packet; optionally start a new one in the same cycle
  task automatic do_eop(input bit en, input bit acc, input int st,
                        input bit ld, input int lsid, input bit lnew);
    bit f;
    eop = 1; enable = en; eng_accept = acc; eng_state_out = SW'(st);
    f = m_flag | acc;
    if (en) begin
      m_valid[m_sid] = 1; m_state[m_sid] = st;
      if (f) begin
        if (m_cnt[m_sid] != CMAX) m_cnt[m_sid]++;
        if (m_total != CMAX) m_total++;
      end
    end else f = 0;
    if (ld) begin
      load_state = 1; stream_id = SIDW'(lsid); new_stream_id = lnew;
      f = 0; m_sid = lsid;
    end
    m_flag = f;
    sb_q.push_back(32'(f));
    sb_q.push_back(32'(m_total));
    if (ld) sb_q.push_back((lnew || !m_valid[lsid]) ? 32'd0 : 32'(m_state[lsid]));
    tick();
    eop = 0; eng_accept = 0; enable = 0; load_state = 0; new_stream_id = 0;
    exp_v = sb_q.pop_front();
    total++;
    if (32'(fired) !== exp_v) begin
      bad++;
      $display("FAIL eop_fired: got %b, want %0d", fired, exp_v);
    end
    exp_v = sb_q.pop_front();
    total++;
    if (32'(total_count) !== exp_v) begin
      bad++;
      $display("FAIL eop_total: got %0d, want %0d", total_count, exp_v);
    end
    if (ld) begin
      exp_v = sb_q.pop_front();
      total++;
      if (eng_state_in_vld !== 1'b1 || 32'(eng_state_in) !== exp_v) begin
        bad++;
        $display("FAIL eop_load sid=%0d: got vld=%b st=%h, want vld=1 st=%h", lsid, eng_state_in_vld, eng_state_in, exp_v);
      end
      tick();
    end
  endtask

  task automatic do_read(input int sid);
    rd_sid = SIDW'(sid);
    sb_q.push_back(32'(m_cnt[sid]));
    tick();
    exp_v = sb_q.pop_front();
    total++;
    if (32'(rd_count) !== exp_v) begin
      bad++;
      $display("FAIL rd_count sid=%0d: got %0d, want %0d", sid, rd_count, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_state = 0; new_stream_id = 0; stream_id = '0; enable = 0;
    char_in_vld = 0; char_in = '0; eop = 0; eng_accept = 0;
    eng_state_out = '0; rd_sid = '0;
    model_reset();
    tick();
    total++;
    if (fired !== 0 || total_count !== '0 || proto_err !== 0 || eng_state_in_vld !== 0 ||
        eng_state_in !== '0 || rd_count !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got f=%b t=%0d p=%b v=%b s=%h r=%0d, want all 0",
               fired, total_count, proto_err, eng_state_in_vld, eng_state_in, rd_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_load(5, 1);
    do_accept();
    do_eop(1, 0, 'h1A3, 0, 0, 0);
    do_read(5);
  endtask

  task automatic test_restore();
    do_load(5, 0);
    do_eop(1, 0, 'h1A3, 0, 0, 0);
    do_load(7, 0);
    do_eop(1, 0, 'h055, 0, 0, 0);
    do_read(7);
  endtask

  task automatic test_back_to_back();
    do_load(3, 1);
    eng_accept = 1;
    char_in_vld = 1; char_in = 8'h5A;
    total++;
    if (eng_char_vld !== 1'b1 || eng_char !== 8'h5A) begin
      bad++;
      $display("FAIL char_forward: got vld=%b ch=%h, want vld=1 ch=5a", eng_char_vld, eng_char);
    end
    tick();
    eng_accept = 0; char_in_vld = 0;
    m_flag = 1;
    do_eop(1, 0, 'h0C3, 1, 4, 0);
    do_eop(1, 0, 'h011, 0, 0, 0);
    do_read(3);
    do_read(4);
    do_load(3, 0);
    do_eop(1, 1, 'h0C3, 0, 0, 0);
    do_read(3);
  endtask

  task automatic test_disable();
    do_load(5, 0);
    do_accept();
    do_eop(0, 0, 'h3FF, 0, 0, 0);
    do_read(5);
    do_load(5, 0);
    do_eop(1, 0, 'h1A3, 0, 0, 0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 17; i++) begin
      do_load(2, i == 0);
      do_accept();
      do_eop(1, 0, 'h100 + i, 0, 0, 0);
    end
    do_read(2);
    total++;
    if (32'(total_count) !== 32'(CMAX)) begin
      bad++;
      $display("FAIL sat_total: got %0d, want %0d", total_count, CMAX);
    end
  endtask

  task automatic test_proto();
    int t0;
    total++;
    if (proto_err !== 1'b0) begin
      bad++;
      $display("FAIL proto_clean: got %b, want 0", proto_err);
    end
    t0 = m_total;
    eop = 1; enable = 1;
    tick();
    eop = 0; enable = 0;
    tick(); tick();
    total++;
    if (proto_err !== 1'b1 || 32'(total_count) !== 32'(t0)) begin
      bad++;
      $display("FAIL proto_eop_idle: got p=%b t=%0d, want p=1 t=%0d", proto_err, total_count, t0);
    end
    apply_reset();
    total++;
    if (proto_err !== 1'b0) begin
      bad++;
      $display("FAIL proto_rst: got %b, want 0", proto_err);
    end
    char_in_vld = 1; char_in = 8'h41;
    tick();
    char_in_vld = 0;
    tick();
    total++;
    if (proto_err !== 1'b1) begin
      bad++;
      $display("FAIL proto_char_idle: got %b, want 1", proto_err);
    end
    // Mid-packet reset: nothing from the abandoned packet may be committed
    apply_reset();
    do_load(6, 1);
    do_accept();
    eng_state_out = SW'('h2AA);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    tick();
    total++;
    if (fired !== 1'b0 || total_count !== '0) begin
      bad++;
      $display("FAIL rst_mid: got f=%b t=%0d, want f=0 t=0", fired, total_count);
    end
    do_load(6, 0);
    do_eop(0, 0, 0, 0, 0, 0);
    do_load(5, 0);
    do_eop(0, 0, 0, 0, 0, 0);
    do_read(5);
    do_read(6);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restore();
    test_back_to_back();
    test_disable();
    test_saturate();
    test_proto();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
